// File: rtl/bp_be_fe_queue_buffer.sv
// Checkpointed fetch-packet FIFO: entries are read speculatively, freed only on commit,
// and may be replayed from the commit point (roll) or discarded wholesale (clear).
module bp_be_fe_queue_buffer #(
  parameter  int bp_params_p       = 0,  // 0 selects the default processor config
  parameter  int els_p             = 8,
  localparam int fe_queue_width_lp = (bp_params_p == 0) ? 64 : 128,
  localparam int ptr_width_lp      = $clog2(els_p) + 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,

  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_o,

  output logic [fe_queue_width_lp-1:0] fe_queue_o,
  output logic                         fe_queue_v_o,
  input  logic                         fe_queue_yumi_i,

  input  logic                         commit_v_i,
  input  logic                         roll_v_i,
  input  logic                         clr_v_i,
  output logic                         empty_o
);

  localparam int idx_width_lp = ptr_width_lp - 1;

  logic [fe_queue_width_lp-1:0] mem_q [els_p];
  logic [ptr_width_lp-1:0]      wptr_q, wptr_d;
  logic [ptr_width_lp-1:0]      rptr_q, rptr_d;
  logic [ptr_width_lp-1:0]      cptr_q, cptr_d;
  logic [ptr_width_lp-1:0]      cptr_next;
  logic [ptr_width_lp-1:0]      one_ptr;

  logic full, enq, commit_ok;

  assign one_ptr = {{(ptr_width_lp-1){1'b0}}, 1'b1};

  // Same index with differing wrap bits means every slot holds an uncommitted entry.
  assign full = (wptr_q[idx_width_lp-1:0] == cptr_q[idx_width_lp-1:0])
              & (wptr_q[ptr_width_lp-1] != cptr_q[ptr_width_lp-1]);

  assign fe_queue_ready_o = ~full;
  assign fe_queue_v_o     = (rptr_q != wptr_q);
  assign empty_o          = (cptr_q == wptr_q);
  assign fe_queue_o       = mem_q[rptr_q[idx_width_lp-1:0]];

  assign enq       = fe_queue_v_i & fe_queue_ready_o & ~clr_v_i;
  assign commit_ok = commit_v_i & (cptr_q != rptr_q);
  assign cptr_next = commit_ok ? (cptr_q + one_ptr) : cptr_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cptr_d = cptr_q;
    if (clr_v_i) begin
      rptr_d = wptr_q;
      cptr_d = wptr_q;
    end else begin
      cptr_d = cptr_next;
      if (enq) wptr_d = wptr_q + one_ptr;
      // Roll lands on the post-commit checkpoint so a same-cycle commit is not replayed.
      if (roll_v_i)             rptr_d = cptr_next;
      else if (fe_queue_yumi_i) rptr_d = rptr_q + one_ptr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq & ~reset_i) mem_q[wptr_q[idx_width_lp-1:0]] <= fe_queue_i;
  end

  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(commit_v_i && !clr_v_i && (cptr_q == rptr_q)));
      assert (!fe_queue_yumi_i || fe_queue_v_o);
    end
  end

endmodule
